sample_feeder: RTL

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder.sv | 78 +++++++
 1 files changed

// File: rtl/sample_feeder.sv
// Sample FIFO between the synthesizer and the PWMDAC; din advances on each din_ack, silence on underrun.
// Optional saturating underrun counter enabled by defining SAMPLE_FEEDER_UNDERRUN_CNT_EN.
module sample_feeder #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic [7:0]        sample_in,
    input  logic              sample_stb,
    output logic              sample_rdy,
    output logic [7:0]        din,
    input  logic              din_ack,
    output logic              underrun,
    output logic [ADDR_W:0]   level
`ifdef SAMPLE_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        underrun_cnt
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic              empty_ack;

    assign sample_rdy = (level != DEPTH);
    assign push       = sample_stb & sample_rdy;
    assign pop        = din_ack & (level != '0);
    assign empty_ack  = din_ack & (level == '0);

    // Storage is not reset; contents are invalidated by clearing the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            din      <= 8'h00;
            underrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                din    <= mem[rd_ptr];
            end else if (empty_ack) begin
                din    <= 8'h00;
            end
            underrun <= empty_ack;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef SAMPLE_FEEDER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            underrun_cnt <= 8'h00;
        end else if (empty_ack && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'h01;
        end
    end
`endif

endmodule
